// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: emits round keys 0..14 over a valid/ready handshake.
// Optional round-key store enabled by defining KEYEXP_RKSTORE_EN.

module aes256_key_expand_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b occupies bits [8*(255-b)+7 -: 8]
  assign o_byte = SBOX[{~i_byte, 3'b111} -: 8];
endmodule

module aes256_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_load,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t         r_state;
  logic [255:0]   r_win;
  logic [127:0]   r_rk_out;
  logic [3:0]     r_rk_idx;
  logic           r_rk_valid;
  logic           r_done;

  logic           w_xfer;
  logic           w_even;
  logic [31:0]    w_rot, w_sub, w_t;
  logic [31:0]    w_a, w_b, w_c, w_d;
  logic [7:0]     w_rcon;

  assign w_xfer = r_rk_valid & rk_ready;
  // Odd current index means the next index is even: RotWord + Rcon path
  assign w_even = r_rk_idx[0];
  assign w_rot  = w_even ? {r_win[23:0], r_win[31:24]} : r_win[31:0];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes256_key_expand_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_rk_idx)
      4'd1:    w_rcon = 8'h01;
      4'd3:    w_rcon = 8'h02;
      4'd5:    w_rcon = 8'h04;
      4'd7:    w_rcon = 8'h08;
      4'd9:    w_rcon = 8'h10;
      4'd11:   w_rcon = 8'h20;
      4'd13:   w_rcon = 8'h40;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_t = w_sub ^ {w_rcon, 24'h000000};
  assign w_a = r_win[255:224] ^ w_t;
  assign w_b = r_win[223:192] ^ w_a;
  assign w_c = r_win[191:160] ^ w_b;
  assign w_d = r_win[159:128] ^ w_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_rk_out   <= '0;
      r_rk_idx   <= '0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (key_load) begin
        r_state    <= ST_RUN;
        r_win      <= key_in;
        r_rk_out   <= key_in[255:128];
        r_rk_idx   <= '0;
        r_rk_valid <= 1'b1;
      end else if (r_state == ST_RUN && w_xfer) begin
        if (r_rk_idx == 4'd14) begin
          r_state    <= ST_IDLE;
          r_rk_valid <= 1'b0;
          r_done     <= 1'b1;
        end else if (r_rk_idx == 4'd0) begin
          // Window already holds w0..w7 for round 1; no shift yet
          r_rk_out <= r_win[127:0];
          r_rk_idx <= 4'd1;
        end else begin
          r_win    <= {r_win[127:0], w_a, w_b, w_c, w_d};
          r_rk_out <= {w_a, w_b, w_c, w_d};
          r_rk_idx <= r_rk_idx + 4'd1;
        end
      end
    end
  end

  assign rk_out   = r_rk_out;
  assign rk_valid = r_rk_valid;
  assign rk_idx   = r_rk_idx;
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;

`ifdef KEYEXP_RKSTORE_EN
  logic [127:0] r_store [15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) r_store[i] <= '0;
    end else if (r_state == ST_RUN && w_xfer && r_rk_idx <= 4'd14) begin
      r_store[r_rk_idx] <= r_rk_out;
    end
  end

  assign rd_key = (rd_idx <= 4'd14) ? r_store[rd_idx] : '0;
`else
  logic w_unused_rd_idx;
  assign w_unused_rd_idx = ^rd_idx;
  assign rd_key = '0;
`endif
endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand: full runs, stalls, restart, async reset, reload after done.
// Round-key expectations come from a word-indexed FIPS-197 expansion model plus hand constants.

module tb_aes256_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic         key_load;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  aes256_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_load (key_load),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K2 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [31:0]  w [60];
  logic [127:0] exp1 [15];
  logic [127:0] exp2 [15];

  function automatic logic [31:0] subw(input logic [31:0] x);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = TB_SBOX[2047 - 8*int'(x[8*j +: 8]) -: 8];
    return r;
  endfunction

  task automatic expand(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h000000};
      else if (i % 8 == 4) t = subw(t);
      w[i] = w[i-8] ^ t;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_key(input string tag, input int r, input logic [127:0] exp);
    chk($sformatf("%s_valid%0d", tag, r), {127'd0, rk_valid}, 128'd1);
    chk($sformatf("%s_idx%0d", tag, r), {124'd0, rk_idx}, 128'(r));
    chk($sformatf("%s_key%0d", tag, r), rk_out, exp);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"},  {127'd0, done},     128'd1);
    chk({tag, "_valid"}, {127'd0, rk_valid}, 128'd0);
    chk({tag, "_busy"},  {127'd0, busy},     128'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_idx;
    bit  fin;

    expand(K1);
    for (int r = 0; r < 15; r++) exp1[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(K2);
    for (int r = 0; r < 15; r++) exp2[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Reset state
    rst_n = 1'b0; key_load = 1'b0; rk_ready = 1'b0; key_in = '0; rd_idx = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_idx",   {124'd0, rk_idx},   128'd0);
    chk("rst_out",   rk_out,             128'd0);
    chk("rst_busy",  {127'd0, busy},     128'd0);
    chk("rst_done",  {127'd0, done},     128'd0);
    rst_n = 1'b1;

    // Full run, rk_ready tied high
    @(negedge clk);
    key_in = K1; key_load = 1'b1; rk_ready = 1'b1;
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      key_load = 1'b0;
      chk_key("run", r, exp1[r]);
      if (r == 0)  chk("hand_idx0",  rk_out, 128'h000102030405060708090a0b0c0d0e0f);
      if (r == 1)  chk("hand_idx1",  rk_out, 128'h101112131415161718191a1b1c1d1e1f);
      if (r == 2)  chk("hand_idx2",  rk_out, 128'ha573c29fa176c498a97fce93a572c09c);
      if (r == 14) chk("hand_idx14", rk_out, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      if (r == 7)  chk("run_busy", {127'd0, busy}, 128'd1);
    end
    @(negedge clk);
    chk_done("run");
    chk("run_hold_out", rk_out, exp1[14]);
    @(negedge clk);
    chk("run_done_pulse", {127'd0, done}, 128'd0);

    // Pseudo-random stalls
    key_in = K1; key_load = 1'b1; rk_ready = 1'b0;
    exp_idx = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      key_load = 1'b0;
      chk_key("stall", exp_idx, exp1[exp_idx]);
      rk_ready = 1'($urandom_range(0, 1));
      if (rk_ready) begin
        if (exp_idx == 14) fin = 1'b1;
        else exp_idx++;
      end
    end
    chk("stall_finished", {127'd0, fin}, 128'd1);
    @(negedge clk);
    chk_done("stall");
    rk_ready = 1'b1;

    // Restart at idx 5 with a transfer in the same cycle
    @(negedge clk);
    key_in = K1; key_load = 1'b1;
    for (int r = 0; r <= 5; r++) begin
      @(negedge clk);
      key_load = 1'b0;
      chk_key("pre", r, exp1[r]);
    end
    key_in = K2; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    chk_key("k2", 0, exp2[0]);
    chk("hand_k2_idx0", rk_out, 128'h603deb1015ca71be2b73aef0857d7781);
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk);
      chk_key("k2", r, exp2[r]);
      if (r == 2) chk("hand_k2_w8", {96'd0, rk_out[127:96]}, 128'h9ba35411);
    end

    // Asynchronous reset mid-schedule at idx 7
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {127'd0, rk_valid}, 128'd0);
    chk("arst_busy",  {127'd0, busy},     128'd0);
    chk("arst_idx",   {124'd0, rk_idx},   128'd0);
    chk("arst_out",   rk_out,             128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_nodone", {127'd0, done}, 128'd0);
    key_in = K1; key_load = 1'b1;
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      key_load = 1'b0;
      chk_key("post", r, exp1[r]);
    end
    @(negedge clk);
    chk_done("post");

    // Reload right after done, consumer not ready for 3 cycles
    key_in = K1; key_load = 1'b1; rk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      key_load = 1'b0;
      chk_key($sformatf("hold%0d", c), 0, exp1[0]);
    end
    rk_ready = 1'b1;
    for (int r = 1; r < 15; r++) begin
      @(negedge clk);
      chk_key("reld", r, exp1[r]);
    end
    @(negedge clk);
    chk_done("reld");
    rk_ready = 1'b0;

    // Round-key store read port
    rd_idx = 4'd2;
    #1;
`ifdef KEYEXP_RKSTORE_EN
    chk("store_rd2", rd_key, 128'ha573c29fa176c498a97fce93a572c09c);
    rd_idx = 4'd14;
    #1;
    chk("store_rd14", rd_key, exp1[14]);
    rd_idx = 4'd15;
    #1;
    chk("store_rd15", rd_key, 128'd0);
`else
    chk("nostore_rd2", rd_key, 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
